// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative radix-2 multiply/divide for the RV32M op subset.
// Define ALU_MULDIV_FAST_MUL_EN for a single-cycle multiply product path.
module alu_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int W  = XLEN;
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};

  localparam logic [5:0] OP_MUL    = 6'h12;
  localparam logic [5:0] OP_MULH   = 6'h13;
  localparam logic [5:0] OP_MULHU  = 6'h14;
  localparam logic [5:0] OP_MULHSU = 6'h15;
  localparam logic [5:0] OP_DIV    = 6'h16;
  localparam logic [5:0] OP_DIVU   = 6'h17;
  localparam logic [5:0] OP_REM    = 6'h18;
  localparam logic [5:0] OP_REMU   = 6'h19;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    FIXUP,
    DONE
  } state_t;

  state_t        state_q;
  logic [5:0]    op_q;
  logic          mul_q;
  logic          sa_q;
  logic          sb_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]  mcd_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          illegal_q;
  logic          busy_q;
  logic [W-1:0]  result_q;

  logic          legal;
  logic          is_mul;
  logic          sgn_a;
  logic          sgn_b;
  logic          b_zero;
  logic          ovf;
  logic          special;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [W-1:0]  spec_res;

  always_comb begin
    legal  = 1'b1;
    is_mul = 1'b0;
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    case (op)
      OP_MUL, OP_MULH: begin
        is_mul = 1'b1;
        sgn_a  = a[W-1];
        sgn_b  = b[W-1];
      end
      OP_MULHSU: begin
        is_mul = 1'b1;
        sgn_a  = a[W-1];
      end
      OP_MULHU: is_mul = 1'b1;
      OP_DIV, OP_REM: begin
        sgn_a = a[W-1];
        sgn_b = b[W-1];
      end
      OP_DIVU, OP_REMU: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign b_zero  = legal && !is_mul && (b == '0);
  assign ovf     = (op == OP_DIV || op == OP_REM)
                && (a == MINV) && (b == '1);
  assign special = !legal || b_zero || ovf;
  assign mag_a   = sgn_a ? -a : a;
  assign mag_b   = sgn_b ? -b : b;

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      !legal:  spec_res = '0;
      b_zero:  spec_res = (op == OP_DIV || op == OP_DIVU) ? '1 : a;
      ovf:     spec_res = (op == OP_DIV) ? MINV : '0;
      default: spec_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] fa;
  logic signed [2*W-1:0] fb;
  logic signed [2*W-1:0] fprod;
  assign fa    = {{W{sgn_a}}, a};
  assign fb    = {{W{sgn_b}}, b};
  assign fprod = fa * fb;
`endif

  // Shared engine: add for shift-add multiply, subtract for restoring divide
  logic [W:0]     lhs;
  logic [W:0]     rhs;
  logic [W+1:0]   sum;
  logic [2*W-1:0] acc_step;

  always_comb begin
    lhs = mul_q ? {1'b0, acc_q[2*W-1:W]} : acc_q[2*W-1:W-1];
    rhs = (mul_q && !acc_q[0]) ? '0 : {1'b0, mcd_q};
    sum = mul_q ? ({1'b0, lhs} + {1'b0, rhs})
                : ({1'b0, lhs} - {1'b0, rhs});
    if (mul_q)
      acc_step = {sum[W:0], acc_q[W-1:1]};
    else if (sum[W+1])
      acc_step = {acc_q[2*W-2:0], 1'b0};
    else
      acc_step = {sum[W-1:0], acc_q[W-2:0], 1'b1};
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem  = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    case (op_q)
      OP_MUL:                       fix_res = prod[W-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU: fix_res = prod[2*W-1:W];
      OP_DIV, OP_DIVU:              fix_res = quo;
      default:                      fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      mul_q       <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      acc_q       <= '0;
      mcd_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!flush && in_valid) begin
            op_q       <= op;
            mul_q      <= is_mul;
            sa_q       <= sgn_a;
            sb_q       <= sgn_b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            illegal_q  <= !legal;
            if (special) begin
              state_q     <= DONE;
              result_q    <= spec_res;
              out_valid_q <= 1'b1;
`ifdef ALU_MULDIV_FAST_MUL_EN
            end else if (is_mul) begin
              state_q <= FIXUP;
              acc_q   <= fprod;
              sa_q    <= 1'b0;
              sb_q    <= 1'b0;
`endif
            end else begin
              state_q <= EXEC;
              mcd_q   <= is_mul ? mag_a : mag_b;
              acc_q   <= {{W{1'b0}}, is_mul ? mag_b : mag_a};
            end
          end
        end
        EXEC: begin
          if (flush) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST)
              state_q <= FIXUP;
          end
        end
        FIXUP: begin
          if (flush) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q     <= DONE;
            result_q    <= fix_res;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: randomized and directed checks of alu_muldiv_unit
// against an arithmetic reference model.
module tb_alu_muldiv_unit;

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_MUL    = 6'h12;
  localparam logic [5:0] OP_MULH   = 6'h13;
  localparam logic [5:0] OP_MULHU  = 6'h14;
  localparam logic [5:0] OP_MULHSU = 6'h15;
  localparam logic [5:0] OP_DIV    = 6'h16;
  localparam logic [5:0] OP_DIVU   = 6'h17;
  localparam logic [5:0] OP_REM    = 6'h18;
  localparam logic [5:0] OP_REMU   = 6'h19;

`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op = 6'h0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        illegal;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [5:0] o,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] r,
                                output logic il,
                                output int lat);
    longint sx, sy, ux, uy, p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'b0, x});
    uy  = longint'({32'b0, y});
    r   = 32'h0;
    il  = 1'b0;
    lat = 34;
    p   = 0;
    case (o)
      OP_MUL:    begin p = sx * sy; r = p[31:0];  lat = MUL_LAT; end
      OP_MULH:   begin p = sx * sy; r = p[63:32]; lat = MUL_LAT; end
      OP_MULHU:  begin p = ux * uy; r = p[63:32]; lat = MUL_LAT; end
      OP_MULHSU: begin p = sx * uy; r = p[63:32]; lat = MUL_LAT; end
      OP_DIV: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r = 32'h8000_0000; lat = 1;
        end else r = $signed(x) / $signed(y);
      end
      OP_REM: begin
        if (y == 0) begin r = x; lat = 1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r = 32'h0; lat = 1;
        end else r = $signed(x) % $signed(y);
      end
      OP_DIVU: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
        else r = x / y;
      end
      OP_REMU: begin
        if (y == 0) begin r = x; lat = 1; end
        else r = x % y;
      end
      default: begin il = 1'b1; lat = 1; end
    endcase
  endfunction

  bit          armed = 1'b0;
  bit          exp_active = 1'b0;
  bit          exp_seen = 1'b0;
  logic [31:0] exp_res;
  logic        exp_ill;
  int          exp_lat;
  int          acc_cyc = 0;
  int          cyc = 0;
  int          last_lat = 0;
  logic [31:0] last_res = 32'h0;
  logic        last_ill = 1'b0;

  // Compare process: every cycle with a live response
  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      if (out_valid) begin
        if (!exp_active) begin
          chk("unexpected_valid", {63'b0, out_valid}, 64'h0);
        end else begin
          if (!exp_seen) begin
            exp_seen = 1'b1;
            last_lat = cyc - acc_cyc;
            last_res = result;
            last_ill = illegal;
            chk("latency", 64'(last_lat), 64'(exp_lat));
          end
          chk("result", {32'b0, result}, {32'b0, exp_res});
          chk("illegal", {63'b0, illegal}, {63'b0, exp_ill});
          chk("in_ready_done", {63'b0, in_ready}, 64'h0);
          chk("busy_done", {63'b0, busy}, 64'h1);
        end
      end else if (exp_active && !exp_seen && (cyc - acc_cyc > exp_lat)) begin
        chk("late_valid", {63'b0, out_valid}, 64'h1);
        exp_active = 1'b0;
      end
      if (rst || flush) exp_active = 1'b0;
      else if (out_valid && out_ready) exp_active = 1'b0;
      else if (in_valid && in_ready) begin
        model(op, a, b, exp_res, exp_ill, exp_lat);
        exp_active = 1'b1;
        exp_seen   = 1'b0;
        acc_cyc    = cyc;
      end
    end
  end

  task automatic accept(input logic [5:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", {63'b0, in_ready}, 64'h1);
    op = o; a = x; b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 6'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (exp_active && n < 300) begin
      if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    chk("resp_timeout", {63'b0, exp_active}, 64'h0);
    exp_active = 1'b0;
  endtask

  task automatic send(input logic [5:0] o, input logic [31:0] x,
                      input logic [31:0] y);
    accept(o, x, y);
    wait_idle(1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'h1);
    chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'h0);
    chk({tag, "_result"}, {32'b0, result}, 64'h0);
    chk({tag, "_illegal"}, {63'b0, illegal}, 64'h0);
    chk({tag, "_busy"}, {63'b0, busy}, 64'h0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mr;
    logic        mi;
    int          ml;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst_init");
    rst   = 1'b0;
    armed = 1'b1;

    // Pin the reference model to hand-computed values
    model(OP_MUL, 32'd7, 32'hFFFF_FFFD, mr, mi, ml);
    chk("m_mul", {32'b0, mr}, 64'hFFFF_FFEB);
    model(OP_MULHSU, 32'h8000_0000, 32'h8000_0000, mr, mi, ml);
    chk("m_mulhsu", {32'b0, mr}, 64'hC000_0000);
    model(OP_REM, 32'hFFFF_FFF9, 32'd2, mr, mi, ml);
    chk("m_rem", {32'b0, mr}, 64'hFFFF_FFFF);
    model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, mr, mi, ml);
    chk("m_ovf_lat", 64'(ml), 64'd1);

    send(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    chk("mul_res", {32'b0, last_res}, 64'hFFFF_FFEB);
    chk("mul_lat", 64'(last_lat), 64'(MUL_LAT));
    chk("mul_ill", {63'b0, last_ill}, 64'h0);
    send(OP_MULH, 32'h8000_0000, 32'h8000_0000);
    chk("mulh_res", {32'b0, last_res}, 64'h4000_0000);
    send(OP_MULHU, 32'h8000_0000, 32'h8000_0000);
    chk("mulhu_res", {32'b0, last_res}, 64'h4000_0000);
    send(OP_MULHSU, 32'h8000_0000, 32'h8000_0000);
    chk("mulhsu_res", {32'b0, last_res}, 64'hC000_0000);
    send(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_res", {32'b0, last_res}, 64'hFFFF_FFFD);
    chk("div_lat", 64'(last_lat), 64'd34);
    send(OP_REM, 32'hFFFF_FFF9, 32'd2);
    chk("rem_res", {32'b0, last_res}, 64'hFFFF_FFFF);
    send(OP_DIVU, 32'd100, 32'd7);
    chk("divu_res", {32'b0, last_res}, 64'd14);
    send(OP_REMU, 32'd100, 32'd7);
    chk("remu_res", {32'b0, last_res}, 64'd2);

    send(OP_DIVU, 32'd5, 32'd0);
    chk("divu0_res", {32'b0, last_res}, 64'hFFFF_FFFF);
    chk("divu0_lat", 64'(last_lat), 64'd1);
    send(OP_REM, 32'd5, 32'd0);
    chk("rem0_res", {32'b0, last_res}, 64'd5);
    chk("rem0_lat", 64'(last_lat), 64'd1);
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_res", {32'b0, last_res}, 64'h8000_0000);
    chk("ovf_lat", 64'(last_lat), 64'd1);
    send(OP_ADD, 32'd1, 32'd2);
    chk("ill_res", {32'b0, last_res}, 64'h0);
    chk("ill_flag", {63'b0, last_ill}, 64'h1);
    chk("ill_lat", 64'(last_lat), 64'd1);

    // Backpressure: hold the response for ten cycles
    out_ready = 1'b0;
    accept(OP_DIVU, 32'd1000, 32'd9);
    for (int n = 0; n < 100 && !exp_seen; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_seen", {63'b0, exp_seen}, 64'h1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("bp_hold_valid", {63'b0, out_valid}, 64'h1);
    chk("bp_hold_res", {32'b0, result}, 64'd111);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", {63'b0, in_ready}, 64'h1);
    chk("bp_idle_valid", {63'b0, out_valid}, 64'h0);
    accept(OP_REMU, 32'd1000, 32'd9);
    chk("bp_next_busy", {63'b0, busy}, 64'h1);
    wait_idle(1'b0);
    chk("bp_next_res", {32'b0, last_res}, 64'd1);

    // Flush at iteration 10 of a divide
    accept(OP_DIV, 32'd12345, 32'd67);
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_valid", {63'b0, out_valid}, 64'h0);
    chk("fl_busy", {63'b0, busy}, 64'h0);
    chk("fl_ready", {63'b0, in_ready}, 64'h1);
    repeat (40) begin
      @(posedge clk); #1;
    end
    chk("fl_quiet", {63'b0, out_valid}, 64'h0);

    // Reset at iteration 20 of a divide
    accept(OP_DIV, 32'd99999, 32'd13);
    repeat (20) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("rst_mid");
    rst = 1'b0;
    send(OP_MUL, 32'd3, 32'd4);
    chk("post_rst_mul", {32'b0, last_res}, 64'd12);

    for (int i = 0; i < 200; i++) begin
      accept(6'h10 + 6'($urandom_range(0, 11)), rnd_val(), rnd_val());
      wait_idle(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
